// File: rtl/banked_ram_ctrl_if.sv
// Request/response bus of banked_ram_ctrl: a valid/ready request channel
// and a single-cycle response pulse.
interface banked_ram_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int BANK_W = 1,
    parameter int ROW_W  = 2,
    parameter int COL_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_bank, req_row, req_col, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_bank, req_row, req_col, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/banked_ram_ctrl.sv
// Multi-bank RAM with open-row policy: per-bank activate/precharge latency
// modelled by a controller FSM, with saturating row hit/miss statistics.
module banked_ram_ctrl #(
    parameter int DATA_W  = 4,
    parameter int BANKS   = 2,
    parameter int ROW_W   = 2,
    parameter int COL_W   = 2,
    parameter int ACT_LAT = 2,
    parameter int PRE_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs,
    input  logic               oe,
    input  logic               flush,
    banked_ram_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    localparam int BANK_W  = (BANKS > 2) ? $clog2(BANKS) : 1;
    localparam int AW      = BANK_W + ROW_W + COL_W;
    localparam int DEPTH   = BANKS << (ROW_W + COL_W);
    localparam int LAT_MAX = (ACT_LAT > PRE_LAT) ? ACT_LAT : PRE_LAT;
    localparam int LW      = $clog2(LAT_MAX + 1);
    localparam logic [LW-1:0]     ACT_M1  = LW'(ACT_LAT - 1);
    localparam logic [LW-1:0]     PRE_M1  = LW'(PRE_LAT - 1);
    localparam logic [BANK_W:0]   BANKS_L = (BANK_W + 1)'(BANKS);

    typedef enum logic [2:0] {IDLE, PRE, ACT, ACCESS, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic [BANKS-1:0]    open_q, open_d;
    logic [ROW_W-1:0]    open_row_q [BANKS];
    logic [ROW_W-1:0]    open_row_d [BANKS];
    logic                we_q, we_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    hit_q, hit_d;
    logic [CNT_W-1:0]    miss_q, miss_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       idx;
    logic                mem_we;
    logic                req_ready;
    logic                accept;
    logic                in_range;

    // Row and column fields fill whole powers of two, so the concatenation
    // of an in-range bank with them stays below DEPTH.
    assign idx       = {bank_q, row_q, col_q};
    assign req_ready = cs & (state_q == IDLE) & ~flush;
    assign accept    = bus.req_valid & req_ready;
    assign in_range  = {1'b0, bus.req_bank} < BANKS_L;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        open_d      = open_q;
        open_row_d  = open_row_q;
        we_d        = we_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = rdata_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs && flush) begin
                    state_d = FLUSH;
                    lat_d   = PRE_M1;
                end else if (accept) begin
                    we_d    = bus.req_we;
                    bank_d  = bus.req_bank;
                    row_d   = bus.req_row;
                    col_d   = bus.req_col;
                    wdata_d = bus.req_wdata;
                    err_d   = ~in_range;
                    if (!in_range) begin
                        state_d = ACCESS;
                    end else if (open_q[bus.req_bank] &&
                                 open_row_q[bus.req_bank] == bus.req_row) begin
                        state_d = ACCESS;
                        hit_d   = (hit_q == '1) ? hit_q : hit_q + CNT_W'(1);
                    end else begin
                        state_d = open_q[bus.req_bank] ? PRE : ACT;
                        lat_d   = open_q[bus.req_bank] ? PRE_M1 : ACT_M1;
                        miss_d  = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
                    end
                end
            end
            PRE: begin
                if (lat_q == '0) begin
                    open_d[bank_q] = 1'b0;
                    state_d        = ACT;
                    lat_d          = ACT_M1;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            ACT: begin
                if (lat_q == '0) begin
                    open_d[bank_q]     = 1'b1;
                    open_row_d[bank_q] = row_q;
                    state_d            = ACCESS;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            ACCESS: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                if (err_q) begin
                    rdata_d = '0;
                end else if (we_q) begin
                    mem_we  = 1'b1;
                    rdata_d = wdata_q;
                end else begin
                    rdata_d = mem[idx];
                end
            end
            FLUSH: begin
                if (lat_q == '0) begin
                    open_d  = '0;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            open_q      <= '0;
            open_row_q  <= '{default: '0};
            we_q        <= 1'b0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            open_q      <= open_d;
            open_row_q  <= open_row_d;
            we_q        <= we_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    // Array contents survive reset; only the in-flight write is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = oe ? rdata_q : '0;
    assign bus.rsp_err   = rsp_err_q;
    assign hit_cnt       = hit_q;
    assign miss_cnt      = miss_q;
endmodule

// File: tb/tb_banked_ram_ctrl.sv
// Directed scoreboard bench for banked_ram_ctrl (3 banks so that bank 3 is
// out of range); a negedge monitor checks latency, data and error flag.
`timescale 1ns/1ps
module tb_banked_ram_ctrl;
    logic        clk = 1'b0;
    logic        rst, cs, oe, flush;
    logic [15:0] hit_cnt, miss_cnt;

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        int         id;
        int         lat;
        time        t_acc;
        bit         chk;
        logic [3:0] rdata;
        bit         err;
    } exp_t;

    exp_t sb[$];

    banked_ram_ctrl_if #(.DATA_W(4), .BANK_W(2), .ROW_W(2), .COL_W(2)) bus ();

    banked_ram_ctrl #(
        .DATA_W(4), .BANKS(3), .ROW_W(2), .COL_W(2),
        .ACT_LAT(2), .PRE_LAT(1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .oe(oe), .flush(flush),
        .bus(bus.slave), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s id=%0d got=%0h want=%0h", name, id, act, exp);
        end
    endtask

    // Response monitor: rsp_valid rises at an edge 10*lat after accept,
    // sampled 5 ns later on the falling edge.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_rsp got=rsp_valid want=no response");
            end else begin
                exp_t e;
                int   lat;
                e   = sb.pop_front();
                lat = int'(($time - 5 - e.t_acc) / 10);
                check("latency", e.id, lat, e.lat);
                check("rsp_err", e.id, {31'd0, bus.rsp_err}, {31'd0, e.err});
                if (e.chk) check("rsp_rdata", e.id, {28'd0, bus.rsp_rdata}, {28'd0, e.rdata});
            end
        end
    end

    task automatic issue(input int id, input bit we, input int bank, input int row,
                         input int col, input logic [3:0] wd, input int lat,
                         input bit chk, input logic [3:0] rd, input bit err,
                         input bit push);
        exp_t e;
        int   waited;
        logic [31:0] b, r, c;
        b = bank; r = row; c = col;
        waited = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_bank  = b[1:0];
        bus.req_row   = r[1:0];
        bus.req_col   = c[1:0];
        bus.req_wdata = wd;
        #1;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (bus.req_ready !== 1'b1) begin
            vectors++;
            errs++;
            $display("FAIL accept_timeout id=%0d got=req_ready %b want=1", id, bus.req_ready);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) begin
                e.id = id; e.lat = lat; e.t_acc = $time;
                e.chk = chk; e.rdata = rd; e.err = err;
                sb.push_back(e);
            end
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int id);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            errs++;
            $display("FAIL rsp_timeout id=%0d got=%0d pending want=0", id, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_cnt(input int id, input int hit, input int miss);
        check("hit_cnt", id, {16'd0, hit_cnt}, hit);
        check("miss_cnt", id, {16'd0, miss_cnt}, miss);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs = 1'b1; oe = 1'b1; flush = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_bank = '0;
        bus.req_row = '0; bus.req_col = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 0, {31'd0, bus.req_ready}, 1);
        check("rst_rsp_valid", 0, {31'd0, bus.rsp_valid}, 0);
        check("rst_rdata", 0, {28'd0, bus.rsp_rdata}, 0);
        check("rst_err", 0, {31'd0, bus.rsp_err}, 0);
        chk_cnt(0, 0, 0);

        // id, we, bank, row, col, wdata, lat, chk, rdata, err, push
        issue(1, 1, 1, 3, 1, 4'b1000, 3, 1, 4'b1000, 0, 1); wait_done(1); chk_cnt(1, 0, 1);
        issue(2, 0, 1, 3, 1, 4'b0000, 1, 1, 4'b1000, 0, 1); wait_done(2); chk_cnt(2, 1, 1);
        issue(3, 1, 0, 3, 3, 4'b1011, 3, 1, 4'b1011, 0, 1); wait_done(3); chk_cnt(3, 1, 2);
        issue(4, 0, 1, 3, 1, 4'b0000, 1, 1, 4'b1000, 0, 1); wait_done(4); chk_cnt(4, 2, 2);
        issue(5, 0, 1, 0, 0, 4'b0000, 4, 0, 4'b0000, 0, 1); wait_done(5); chk_cnt(5, 2, 3);

        // Flush: ready low on the request cycle and for PRE_LAT cycles after.
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush_ready0", 6, {31'd0, bus.req_ready}, 0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_ready1", 6, {31'd0, bus.req_ready}, 0);
        @(negedge clk);
        #1 check("flush_ready2", 6, {31'd0, bus.req_ready}, 1);
        issue(7, 0, 0, 3, 3, 4'b0000, 3, 1, 4'b1011, 0, 1); wait_done(7); chk_cnt(7, 2, 4);

        // cs low blocks accepts even with req_valid held.
        @(negedge clk);
        cs = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_bank = 2'd0;
        bus.req_row = 2'd3; bus.req_col = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1 check("cs0_ready", 8, {31'd0, bus.req_ready}, 0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        cs = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt(8, 2, 4);

        oe = 1'b0;
        issue(9, 0, 0, 3, 3, 4'b0000, 1, 1, 4'b0000, 0, 1); wait_done(9); chk_cnt(9, 3, 4);
        oe = 1'b1;

        issue(10, 0, 3, 1, 1, 4'b0000, 1, 1, 4'b0000, 1, 1); wait_done(10); chk_cnt(10, 3, 4);
        issue(11, 1, 2, 1, 2, 4'b0101, 3, 1, 4'b0101, 0, 1); wait_done(11); chk_cnt(11, 3, 5);
        issue(12, 0, 2, 1, 2, 4'b0000, 1, 1, 4'b0101, 0, 1); wait_done(12); chk_cnt(12, 4, 5);

        // Reset while the write is in ACT: it must vanish without a response.
        issue(13, 1, 1, 3, 1, 4'b0110, 0, 0, 4'b0000, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk_cnt(13, 0, 0);
        check("post_rst_ready", 13, {31'd0, bus.req_ready}, 1);
        issue(14, 0, 1, 3, 1, 4'b0000, 3, 1, 4'b1000, 0, 1); wait_done(14); chk_cnt(14, 0, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", 15, sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
